// File: rtl/fifo_burst_writer.sv
// Burst producer for the FIFO push port: one command (base, len) becomes len words {last, base+k}.
// Optional inter-word idle gap enabled by defining FIFO_BURST_WRITER_GAP_EN.
module fifo_burst_writer #(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 256,
    parameter int GAP_WIDTH  = 4,
    localparam int LEN_W     = $clog2(MAX_BURST + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [DATA_WIDTH-1:0] cmd_base_i,
    input  logic [LEN_W-1:0]      cmd_len_i,
`ifdef FIFO_BURST_WRITER_GAP_EN
    input  logic [GAP_WIDTH-1:0]  cmd_gap_i,
`endif
    output logic                  push_valid_o,
    input  logic                  push_grant_i,
    output logic [DATA_WIDTH:0]   push_data_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [LEN_W-1:0]      words_sent_o
);

`ifdef FIFO_BURST_WRITER_GAP_EN
    typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, GAP = 2'd2, DONE = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, DONE = 2'd3} state_t;
`endif

    function automatic logic [DATA_WIDTH:0] make_word(input logic last,
                                                      input logic [DATA_WIDTH-1:0] payload);
        return {last, payload};
    endfunction

    state_t                state_r, state_n;
    logic [LEN_W-1:0]      remain_r, remain_n;
    logic [LEN_W-1:0]      sent_r, sent_n;
    logic                  valid_r, valid_n;
    logic [DATA_WIDTH:0]   data_r, data_n;
    logic                  done_r, done_n;
    logic                  ready_r, ready_n;
    logic                  busy_r, busy_n;
    logic [LEN_W-1:0]      len_clamp_s;
    logic [DATA_WIDTH-1:0] next_payload_s;
    logic [GAP_WIDTH-1:0]  gap_len_s;

`ifdef FIFO_BURST_WRITER_GAP_EN
    logic [GAP_WIDTH-1:0]  gap_len_r, gap_len_n;
    logic [GAP_WIDTH-1:0]  gap_cnt_r, gap_cnt_n;
    assign gap_len_s = gap_len_r;
`else
    assign gap_len_s = {GAP_WIDTH{1'b0}};
`endif

    assign len_clamp_s    = (cmd_len_i > LEN_W'(MAX_BURST)) ? LEN_W'(MAX_BURST) : cmd_len_i;
    assign next_payload_s = data_r[DATA_WIDTH-1:0] + {{(DATA_WIDTH-1){1'b0}}, 1'b1};

    // Next-state and next-output decode for the burst sequencer
    always_comb begin
        state_n  = state_r;
        remain_n = remain_r;
        sent_n   = sent_r;
        valid_n  = valid_r;
        data_n   = data_r;
        done_n   = 1'b0;
`ifdef FIFO_BURST_WRITER_GAP_EN
        gap_len_n = gap_len_r;
        gap_cnt_n = gap_cnt_r;
`endif
        case (state_r)
            IDLE: begin
                if (cmd_valid_i) begin
                    sent_n   = {LEN_W{1'b0}};
                    remain_n = len_clamp_s;
`ifdef FIFO_BURST_WRITER_GAP_EN
                    gap_len_n = cmd_gap_i;
`endif
                    if (len_clamp_s != {LEN_W{1'b0}}) begin
                        state_n = SEND;
                        valid_n = 1'b1;
                        data_n  = make_word(len_clamp_s == LEN_W'(1), cmd_base_i);
                    end else begin
                        state_n = DONE;
                        done_n  = 1'b1;
                    end
                end else begin
                    state_n = IDLE;
                end
            end
            SEND: begin
                if (push_grant_i) begin
                    sent_n   = sent_r + LEN_W'(1);
                    remain_n = remain_r - LEN_W'(1);
                    if (remain_r == LEN_W'(1)) begin
                        state_n = DONE;
                        valid_n = 1'b0;
                        data_n  = {(DATA_WIDTH+1){1'b0}};
                        done_n  = 1'b1;
                    end else begin
                        data_n = make_word(remain_r == LEN_W'(2), next_payload_s);
                        if (gap_len_s == {GAP_WIDTH{1'b0}}) begin
                            valid_n = 1'b1;
                        end
`ifdef FIFO_BURST_WRITER_GAP_EN
                        else begin
                            // next word is staged now and simply held through the gap
                            state_n   = GAP;
                            valid_n   = 1'b0;
                            gap_cnt_n = gap_len_s;
                        end
`else
                        else begin
                            valid_n = 1'b1;
                        end
`endif
                    end
                end else begin
                    state_n = SEND;
                end
            end
`ifdef FIFO_BURST_WRITER_GAP_EN
            GAP: begin
                if (gap_cnt_r == GAP_WIDTH'(1)) begin
                    state_n = SEND;
                    valid_n = 1'b1;
                end else begin
                    gap_cnt_n = gap_cnt_r - GAP_WIDTH'(1);
                end
            end
`endif
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
                valid_n = 1'b0;
                data_n  = {(DATA_WIDTH+1){1'b0}};
            end
        endcase
        ready_n = (state_n == IDLE);
        busy_n  = (state_n != IDLE);
    end

    // State and registered-output update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            remain_r <= {LEN_W{1'b0}};
            sent_r   <= {LEN_W{1'b0}};
            valid_r  <= 1'b0;
            data_r   <= {(DATA_WIDTH+1){1'b0}};
            done_r   <= 1'b0;
            ready_r  <= 1'b1;
            busy_r   <= 1'b0;
`ifdef FIFO_BURST_WRITER_GAP_EN
            gap_len_r <= {GAP_WIDTH{1'b0}};
            gap_cnt_r <= {GAP_WIDTH{1'b0}};
`endif
        end else begin
            state_r  <= state_n;
            remain_r <= remain_n;
            sent_r   <= sent_n;
            valid_r  <= valid_n;
            data_r   <= data_n;
            done_r   <= done_n;
            ready_r  <= ready_n;
            busy_r   <= busy_n;
`ifdef FIFO_BURST_WRITER_GAP_EN
            gap_len_r <= gap_len_n;
            gap_cnt_r <= gap_cnt_n;
`endif
        end
    end

    assign cmd_ready_o  = ready_r;
    assign push_valid_o = valid_r;
    assign push_data_o  = data_r;
    assign busy_o       = busy_r;
    assign done_o       = done_r;
    assign words_sent_o = sent_r;

endmodule

// File: tb/tb_fifo_burst_writer.sv
// Scoreboard bench for fifo_burst_writer (default build): random bursts and grants against a word-list model.
module tb_fifo_burst_writer;
    localparam int DW = 32;
    localparam int MB = 256;
    localparam int LW = $clog2(MB + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid_i;
    logic          cmd_ready_o;
    logic [DW-1:0] cmd_base_i;
    logic [LW-1:0] cmd_len_i;
    logic          push_valid_o;
    logic          push_grant_i;
    logic [DW:0]   push_data_o;
    logic          busy_o;
    logic          done_o;
    logic [LW-1:0] words_sent_o;

    always #5 clk = ~clk;

    fifo_burst_writer #(.DATA_WIDTH(DW), .MAX_BURST(MB), .GAP_WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_base_i(cmd_base_i), .cmd_len_i(cmd_len_i),
        .push_valid_o(push_valid_o), .push_grant_i(push_grant_i), .push_data_o(push_data_o),
        .busy_o(busy_o), .done_o(done_o), .words_sent_o(words_sent_o)
    );

    int total = 0;
    int bad = 0;
    logic [DW:0] exp_q[$];
    int          exp_done_q[$];
    int          done_cnt = 0;
    bit          mon_en = 1'b0;
    int          grant_pct = 100;
    logic [DW:0] held;
    bit          held_v = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        total++;
        bad++;
        $display("FAIL %s: got event, expected none", name);
    endtask

    // Reference model: a burst is just the list of words base+k, last on k==n-1
    task automatic model_cmd(input logic [DW-1:0] base, input int len, output int n);
        logic [DW-1:0] b;
        n = (len > MB) ? MB : len;
        for (int k = 0; k < n; k++) begin
            b = base + k;
            exp_q.push_back({(k == n - 1), b});
        end
        exp_done_q.push_back(n);
    endtask

    // Random grant, changed just after each rising edge
    initial begin
        push_grant_i = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            push_grant_i = ($urandom_range(99) < grant_pct);
        end
    end

    // Monitor: compare transferred words, stall stability and done against scoreboard
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            if (held_v) begin
                check("valid_held", {63'd0, push_valid_o}, 64'd1);
                if (push_valid_o) check("data_stable", {31'd0, push_data_o}, {31'd0, held});
            end
            held_v = 1'b0;
            if (push_valid_o) begin
                if (push_grant_i) begin
                    if (exp_q.size() == 0) flag("unexpected_word");
                    else check("word", {31'd0, push_data_o}, {31'd0, exp_q.pop_front()});
                end else begin
                    held = push_data_o;
                    held_v = 1'b1;
                end
            end
            if (done_o) begin
                check("done_all_words", 64'(exp_q.size()), 64'd0);
                check("busy_in_done", {63'd0, busy_o}, 64'd1);
                if (exp_done_q.size() == 0) flag("unexpected_done");
                else check("words_sent_at_done", 64'(words_sent_o), 64'(exp_done_q.pop_front()));
                done_cnt++;
            end
        end
    end

    task automatic run_cmd(input logic [DW-1:0] base, input int len);
        int n;
        int start;
        int c;
        check("ready_before_cmd", {63'd0, cmd_ready_o}, 64'd1);
        cmd_valid_i = 1'b1;
        cmd_base_i  = base;
        cmd_len_i   = LW'(len);
        model_cmd(base, len, n);
        start = done_cnt;
        @(posedge clk);
        #1;
        cmd_valid_i = 1'b0;
        cmd_base_i  = $urandom;
        cmd_len_i   = LW'($urandom);
        check("ready_after_accept", {63'd0, cmd_ready_o}, 64'd0);
        check("first_valid_latency", {63'd0, push_valid_o}, {63'd0, (n > 0)});
        c = 0;
        while (c < 3000 && done_cnt == start) begin
            @(posedge clk);
            c++;
        end
        #1;
        if (done_cnt == start) begin
            total++;
            bad++;
            $display("FAIL done_timeout: got no done after %0d cycles, required done", c);
        end else begin
            if (grant_pct == 100) check("burst_cycles", 64'(c), 64'(n + 1));
            check("ready_after_done", {63'd0, cmd_ready_o}, 64'd1);
            check("busy_after_done", {63'd0, busy_o}, 64'd0);
            check("words_sent_held", 64'(words_sent_o), 64'(n));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, {63'd0, cmd_ready_o}, 64'd1);
        check({tag, "_valid"}, {63'd0, push_valid_o}, 64'd0);
        check({tag, "_data"}, {31'd0, push_data_o}, 64'd0);
        check({tag, "_busy"}, {63'd0, busy_o}, 64'd0);
        check({tag, "_done"}, {63'd0, done_o}, 64'd0);
        check({tag, "_words"}, 64'(words_sent_o), 64'd0);
    endtask

    initial begin
        int len;
        logic [DW-1:0] base;
        rst_n = 1'b0;
        cmd_valid_i = 1'b0;
        cmd_base_i = '0;
        cmd_len_i = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        grant_pct = 100;
        run_cmd(32'h0000_0010, 4);
        run_cmd(32'hFFFF_FFFE, 3);
        run_cmd(32'h1234_5678, 0);
        run_cmd(32'hABCD_0000, 1);
        grant_pct = 40;
        run_cmd(32'h0000_0100, 4);

        // Reset mid-burst after two of eight words
        grant_pct = 100;
        cmd_valid_i = 1'b1;
        cmd_base_i = 32'h0000_2000;
        cmd_len_i = LW'(8);
        @(posedge clk);
        #1;
        cmd_valid_i = 1'b0;
        exp_q.push_back({1'b0, 32'h0000_2000});
        exp_q.push_back({1'b0, 32'h0000_2001});
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midburst_reset");
        check("words_before_reset", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        exp_done_q.delete();
        held_v = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_cmd(32'h0000_3000, 2);

        // Randomized bursts, grants and clamped lengths
        for (int i = 0; i < 40; i++) begin
            grant_pct = (i % 4 == 0) ? 100 : int'($urandom_range(30, 95));
            base = (i % 5 == 0) ? (32'hFFFF_FFF0 + DW'($urandom_range(15))) : $urandom;
            if (i % 13 == 5) len = MB + int'($urandom_range(1, 255));
            else if (i % 7 == 3) len = 0;
            else len = int'($urandom_range(1, 20));
            run_cmd(base, len);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
